// File: rtl/minisys_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access widths, FSM states
// and the alignment rule used by both the unit and its lane aligner.
package minisys_mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;  // 2'd3 is also treated as word

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } mau_state_e;

    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        logic mis;
        if (width == WIDTH_BYTE) begin
            mis = 1'b0;
        end else if (width == WIDTH_HALF) begin
            mis = lane[0];
        end else begin
            mis = |lane;
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the MEM-stage access unit (master) and the
// memory/IO responder (slave).
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic        bus_io;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-replicated
// write data, plus load data extraction with sign/zero extension.
module mem_lane_align
    import minisys_mem_pkg::*;
(
    input  logic [1:0]  st_width,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_width,
    input  logic [1:0]  ld_lane,
    input  logic        ld_sign,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    logic [31:0] ld_shifted;

    // Store side: enables and replicated data for the addressed lanes
    always_comb begin
        st_be    = 4'hF;
        st_wdata = st_data;
        case (st_width)
            WIDTH_BYTE: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            WIDTH_HALF: begin
                st_be    = 4'b0011 << {st_lane[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            WIDTH_WORD, 2'd3: begin
                st_be    = 4'hF;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    // Load side: move the addressed lane down to bit 0, then extend
    always_comb begin
        ld_shifted = ld_data >> {ld_lane, 3'b000};
        ld_result  = ld_shifted;
        case (ld_width)
            WIDTH_BYTE: ld_result = {{24{ld_sign & ld_shifted[7]}}, ld_shifted[7:0]};
            WIDTH_HALF: ld_result = {{16{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
            default:    ld_result = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory/IO access unit. Converts pipeline load/store requests into
// a req/ack bus transaction, stalls the pipeline while the bus is busy and
// flags misaligned accesses.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abandon accesses that see no
// ack within TIMEOUT_CYCLES WAIT cycles.
module mem_access_unit
    import minisys_mem_pkg::*;
`ifdef MEM_BUS_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      io_read,
    input  logic                      io_write,
    input  logic                      mem_sign,
    input  logic [1:0]                mem_width,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic                      mem_stall,
    output logic [31:0]               mem_rdata,
    output logic                      addr_err_load,
    output logic                      addr_err_store,
    output logic                      bus_timeout,
    mem_access_unit_if.master         bus
);

    mau_state_e  state_q, state_d;
    logic        flushed_q, flushed_d;
    logic        req_q, we_q, io_q, sign_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q, rdata_q;
    logic [1:0]  width_q, lane_q;

    logic        access, is_write, misaligned;
    logic        start, complete, capture;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_result;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timed_out;
`endif

    assign access     = mem_read | mem_write | io_read | io_write;
    assign is_write   = mem_write | io_write;
    assign misaligned = is_misaligned(mem_width, mem_addr[1:0]);

    assign addr_err_store = is_write & misaligned;
    assign addr_err_load  = access & ~is_write & misaligned;

    mem_lane_align u_align (
        .st_width  (mem_width),
        .st_lane   (mem_addr[1:0]),
        .st_data   (mem_wdata),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_width  (width_q),
        .ld_lane   (lane_q),
        .ld_sign   (sign_q),
        .ld_data   (bus.bus_rdata),
        .ld_result (ld_result)
    );

    // Next-state, stall and transaction strobes
    always_comb begin
        state_d   = state_q;
        flushed_d = flushed_q;
        mem_stall = 1'b0;
        start     = 1'b0;
        complete  = 1'b0;
        capture   = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        timed_out = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (access && !misaligned && !flush) begin
                    start     = 1'b1;
                    mem_stall = 1'b1;
                    flushed_d = 1'b0;
                    state_d   = StWait;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            StWait: begin
                mem_stall = 1'b1;
                // A flush cannot retract the bus cycle; remember it until ack
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus.bus_ack) begin
                    complete = 1'b1;
                    if (flushed_q || flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                        capture = ~we_q;
                    end
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timed_out = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched bus request and load result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            flushed_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            width_q   <= '0;
            lane_q    <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            flushed_q <= flushed_d;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= is_write;
                io_q    <= is_write ? io_write : io_read;
                sign_q  <= mem_sign;
                addr_q  <= mem_addr[31:2];
                be_q    <= st_be;
                wdata_q <= st_wdata;
                width_q <= mem_width;
                lane_q  <= mem_addr[1:0];
            end
            if (complete) begin
                req_q <= 1'b0;
            end
            if (capture) begin
                rdata_q <= ld_result;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timed_out;
            if (timed_out) begin
                req_q   <= 1'b0;
                rdata_q <= '0;
            end
`endif
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_io    = io_q;
    assign bus.bus_addr  = {addr_q, 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign mem_rdata     = rdata_q;

`ifdef MEM_BUS_TIMEOUT_EN
    assign bus_timeout = timeout_q;
`else
    assign bus_timeout = 1'b0;
`endif

endmodule
